clk_ce_gen: RTL and testbench

CLK_CE_GEN -- requirements
Module: clk_ce_gen

---
 rtl/clk_ce_gen_pkg.sv | 19 +
 rtl/clk_ce_gen_if.sv | 18 +
 rtl/clk_ce_gen_chan.sv | 76 +++++++
 rtl/clk_ce_gen.sv | 94 +++++++++
 tb/tb_clk_ce_gen.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_ce_gen_pkg.sv
// Shared lock-FSM state type, default parameters and a width helper.
// No logic, no latency, no backpressure.
package clk_ce_gen_pkg;

    localparam int DEF_CHANNELS = 2;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_SETTLE   = 16;

    typedef enum logic [1:0] {
        LK_WAIT     = 2'd0,
        LK_SETTLING = 2'd1,
        LK_LOCKED   = 2'd2
    } lock_state_e;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_ce_gen_if.sv
// Configuration write channel: valid/ready handshake carrying target channel and increment.
// Pure wiring; ready is driven by the slave and is low while any increment is still pending.
interface clk_ce_gen_if
    import clk_ce_gen_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int ACC_W    = DEF_ACC_W
);
    localparam int CW = chan_w(CHANNELS);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CW-1:0]    cfg_chan;
    logic [ACC_W-1:0] cfg_inc;

    modport master (output cfg_valid, output cfg_chan, output cfg_inc, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_chan, input cfg_inc, output cfg_ready);
endinterface

// File: rtl/clk_ce_gen_chan.sv
// One phase-accumulator channel: ce/outclk registered one cycle after the add.
// No backpressure; a written increment waits as pending until the next wrap (or at once when stopped/synced).
module clk_ce_gen_chan
    import clk_ce_gen_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [ACC_W-1:0] wr_inc_i,
    output logic             ce_o,
    output logic             outclk_o,
    output logic             pend_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pinc_q, pinc_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic             oc_q, oc_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
        acc_d  = sum[ACC_W-1:0];
        ce_d   = sum[ACC_W];
        inc_d  = inc_q;
        pend_d = pend_q;
        pinc_d = pinc_q;
        if (sync_i) begin
            acc_d  = '0;
            ce_d   = 1'b0;
            pend_d = 1'b0;
            if (wr_i)
                inc_d = wr_inc_i;
            else if (pend_q)
                inc_d = pinc_q;
        end else begin
            // Swapping only on the wrap keeps every period whole, so no runt pulse.
            if (pend_q && (sum[ACC_W] || inc_q == '0)) begin
                inc_d  = pinc_q;
                pend_d = 1'b0;
            end
            if (wr_i) begin
                pend_d = 1'b1;
                pinc_d = wr_inc_i;
            end
        end
        oc_d = acc_d[ACC_W-1];
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            inc_q  <= '0;
            pinc_q <= '0;
            pend_q <= 1'b0;
            ce_q   <= 1'b0;
            oc_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            pinc_q <= pinc_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
            oc_q   <= oc_d;
        end
    end

    assign ce_o     = ce_q;
    assign outclk_o = oc_q;
    assign pend_o   = pend_q;
endmodule

// File: rtl/clk_ce_gen.sv
// Multi-channel clock-enable generator with config handshake, phase sync and lock indication.
// ce/outclk one cycle after the add; cfg_ready low while any channel holds a pending increment.
module clk_ce_gen
    import clk_ce_gen_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SETTLE   = DEF_SETTLE
) (
    input  logic                refclk,
    input  logic                rst_n,
    clk_ce_gen_if.slave         cfg,
    input  logic                sync_req,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] outclk,
    output logic                locked
);
    localparam int CNT_W = $clog2(SETTLE + 1);

    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] wr;
    logic [31:0]         chan_ext;
    logic                wr_ok;
    logic                any_pend;

    assign any_pend      = |pend;
    assign cfg.cfg_ready = ~any_pend;
    assign chan_ext      = 32'(cfg.cfg_chan);
    // Out-of-range targets complete the handshake but touch nothing.
    assign wr_ok = cfg.cfg_valid && cfg.cfg_ready && (chan_ext < 32'(CHANNELS));

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign wr[g] = wr_ok && (chan_ext == 32'(g));
        clk_ce_gen_chan #(.ACC_W(ACC_W)) u_chan (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .sync_i   (sync_req),
            .wr_i     (wr[g]),
            .wr_inc_i (cfg.cfg_inc),
            .ce_o     (ce[g]),
            .outclk_o (outclk[g]),
            .pend_o   (pend[g])
        );
    end

    lock_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             locked_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LK_WAIT;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else if (wr_ok || sync_req) begin
            state_q  <= LK_WAIT;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                LK_WAIT: begin
                    cnt_q <= '0;
                    if (!any_pend)
                        state_q <= LK_SETTLING;
                end
                LK_SETTLING: begin
                    if (any_pend) begin
                        state_q <= LK_WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        state_q  <= LK_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LK_LOCKED: begin
                    if (any_pend) begin
                        state_q  <= LK_WAIT;
                        cnt_q    <= '0;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= LK_WAIT;
                    cnt_q    <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign locked = locked_q;
endmodule

// File: tb/tb_clk_ce_gen.sv
// Self-checking bench for clk_ce_gen (2 channels, 8-bit accumulators, settle of 4).
module tb_clk_ce_gen;
    import clk_ce_gen_pkg::*;

    localparam int CH  = 2;
    localparam int AW  = 8;
    localparam int ST  = 4;
    localparam int MOD = 256;
    localparam int CW  = chan_w(CH);

    logic          refclk   = 1'b0;
    logic          rst_n    = 1'b1;
    logic          sync_req = 1'b0;
    logic [CH-1:0] ce;
    logic [CH-1:0] outclk;
    logic          locked;

    clk_ce_gen_if #(.CHANNELS(CH), .ACC_W(AW)) cfg ();

    clk_ce_gen #(.CHANNELS(CH), .ACC_W(AW), .SETTLE(ST)) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .cfg      (cfg.slave),
        .sync_req (sync_req),
        .ce       (ce),
        .outclk   (outclk),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model: phase as a plain integer in [0, 256), wrap when the sum reaches 256.
    int ph[CH];
    int inc[CH];
    int pv[CH];
    bit pd[CH];
    bit e_ce[CH];
    int quiet;

    int npass = 0;
    int ntot  = 0;

    int cyc = 0;
    int last[CH];
    int mingap[CH];
    int maxgap[CH];
    int cnt[CH];
    int hi[CH];
    int both;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit m_anyp();
        bit r = 1'b0;
        for (int i = 0; i < CH; i++) r |= pd[i];
        return r;
    endfunction

    task automatic clr_stats();
        for (int i = 0; i < CH; i++) begin
            last[i] = -1; mingap[i] = 1000000; maxgap[i] = 0; cnt[i] = 0; hi[i] = 0;
        end
        both = 0;
    endtask

    task automatic tick(input bit v, input int ch, input int w, input bit s);
        bit anyp, rdy, wok;
        int sum;
        anyp = m_anyp();
        rdy  = !anyp;
        cfg.cfg_valid = v;
        cfg.cfg_chan  = CW'(ch);
        cfg.cfg_inc   = AW'(w);
        sync_req      = s;
        chk("cfg_ready", {31'd0, cfg.cfg_ready}, {31'd0, rdy});
        wok = v && rdy && (ch < CH);
        for (int i = 0; i < CH; i++) begin
            if (s) begin
                ph[i] = 0;
                e_ce[i] = 1'b0;
                if (wok && ch == i) inc[i] = w;
                else if (pd[i]) inc[i] = pv[i];
                pd[i] = 1'b0;
            end else begin
                sum = ph[i] + inc[i];
                e_ce[i] = (sum >= MOD);
                ph[i] = sum % MOD;
                if (pd[i] && (e_ce[i] || inc[i] == 0)) begin
                    inc[i] = pv[i];
                    pd[i] = 1'b0;
                end
                if (wok && ch == i) begin
                    pd[i] = 1'b1;
                    pv[i] = w;
                end
            end
        end
        quiet = (wok || s || anyp) ? 0 : quiet + 1;
        @(posedge refclk);
        #1;
        cyc++;
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("ce%0d", i), {31'd0, ce[i]}, {31'd0, e_ce[i]});
            chk($sformatf("outclk%0d", i), {31'd0, outclk[i]}, {31'd0, (ph[i] >= MOD / 2)});
            if (outclk[i] === 1'b1) hi[i]++;
            if (ce[i] === 1'b1) begin
                if (last[i] >= 0) begin
                    if (cyc - last[i] < mingap[i]) mingap[i] = cyc - last[i];
                    if (cyc - last[i] > maxgap[i]) maxgap[i] = cyc - last[i];
                end
                last[i] = cyc;
                cnt[i]++;
            end
        end
        if (ce[0] === 1'b1 && ce[1] === 1'b1) both++;
        chk("locked", {31'd0, locked}, {31'd0, (quiet >= ST + 1)});
        cfg.cfg_valid = 1'b0;
        sync_req      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int ch, input int w, input bit s);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            if (!m_anyp()) begin
                tick(1'b1, ch, w, s);
                done = 1'b1;
            end else begin
                tick(1'b0, 0, 0, 1'b0);
            end
        end
        chk("wr_accept_in_time", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < CH; i++) begin
            ph[i] = 0; inc[i] = 0; pv[i] = 0; pd[i] = 1'b0; e_ce[i] = 1'b0;
        end
        quiet = 0;
        chk("rst_ce", {30'd0, ce}, 32'd0);
        chk("rst_outclk", {30'd0, outclk}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_ready", {31'd0, cfg.cfg_ready}, 32'd1);
        repeat (2) @(posedge refclk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_chan  = '0;
        cfg.cfg_inc   = '0;
        clr_stats();
        #2;
        do_reset();

        // Idle after reset: lock appears on the fifth edge.
        idle(4);
        chk("lock_not_yet", {31'd0, locked}, 32'd0);
        idle(1);
        chk("lock_after_reset", {31'd0, locked}, 32'd1);

        // Channel 0 at 64: period 4, two high / two low.
        wr(0, 64, 1'b0);
        idle(1);
        clr_stats();
        idle(16);
        chk("b_ce0_count", cnt[0], 32'd4);
        chk("b_outclk0_high", hi[0], 32'd8);
        chk("b_locked", {31'd0, locked}, 32'd1);

        // Channel 1 at 3: three wraps in 256 adds, periods 85/86.
        wr(1, 3, 1'b0);
        idle(1);
        clr_stats();
        idle(256);
        chk("c_ce1_count", cnt[1], 32'd3);
        chk("c_gap_lo", {31'd0, (mingap[1] >= 85)}, 32'd1);
        chk("c_gap_hi", {31'd0, (maxgap[1] <= 86)}, 32'd1);

        // Retune channel 0 mid-period.
        idle(2);
        clr_stats();
        wr(0, 128, 1'b0);
        chk("d_locked_drop", {31'd0, locked}, 32'd0);
        k = 0;
        while (cfg.cfg_ready !== 1'b1 && k < 10) begin
            tick(1'b0, 0, 0, 1'b0);
            k++;
        end
        chk("d_ready_wait", {31'd0, (k >= 1 && k <= 4)}, 32'd1);
        idle(20);
        chk("d_min_gap", {31'd0, (mingap[0] >= 2)}, 32'd1);
        chk("d_relock", {31'd0, locked}, 32'd1);

        // Both channels at 32, then sync aligns them.
        wr(0, 32, 1'b0);
        wr(1, 32, 1'b0);
        idle(5);
        tick(1'b0, 0, 0, 1'b1);
        chk("e_sync_outclk", {30'd0, outclk}, 32'd0);
        clr_stats();
        idle(32);
        chk("e_ce0_count", cnt[0], 32'd4);
        chk("e_ce1_count", cnt[1], 32'd4);
        chk("e_coincident", both, 32'd4);

        // Writing zero stops channel 0 after its next wrap.
        wr(0, 0, 1'b0);
        idle(20);
        clr_stats();
        idle(20);
        chk("stop_no_ce0", cnt[0], 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, CH - 1)),
                 ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255)),
                 ($urandom_range(0, 49) == 0));
        end

        // Reset while an increment is pending discards it.
        wr(0, 1, 1'b1);
        wr(0, 200, 1'b0);
        chk("g_pending_seen", {31'd0, cfg.cfg_ready}, 32'd0);
        do_reset();
        clr_stats();
        idle(20);
        chk("g_no_ce0", cnt[0], 32'd0);
        chk("g_no_ce1", cnt[1], 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
